addsub_serial_nbit: RTL and testbench
=====================================

Name: addsub_serial_nbit

Overview:
- Parametrised, multi-cycle two's-complement adder/subtractor.
- Processes a WIDTH-bit operand pair DIGIT bits per clock, using a registered carry chain between digits.
- Valid/ready handshake on both sides; adds signed-overflow and zero flags.
- Sits between operand-source logic and the result consumer in the datapath. Replaces the fixed 4-bit combinational add/sub where area matters more than latency.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per clock; 1 ≤ DIGIT ≤ WIDTH. NDIG = WIDTH/DIGIT.

Ports:
- i_clk  input  1  clock, rising-edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  operand pair valid.
- o_ready  output  1  block can accept operands.
- i_A  input  WIDTH  operand A.
- i_B  input  WIDTH  operand B.
- i_mode  input  1  0 = A+B, 1 = A−B.
- o_valid  output  1  result valid.
- i_ready  input  1  consumer accepts result.
- o_sum  output  WIDTH  result.
- o_carry  output  1  carry out of MSB (subtract: 1 = no borrow).
- o_ovf  output  1  signed overflow.
- o_zero  output  1  o_sum == 0.

Behaviour:
- One clock, i_clk. Reset i_rst_n is asynchronous, active-low.
- Reset values: state IDLE, o_ready=1, o_valid=0, o_sum=0, o_carry=0, o_ovf=0, o_zero=0. Digit counter, carry register and operand registers are all 0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - o_ready=1.
  - On i_valid & o_ready at a rising edge: capture i_A, B' = i_B ^ {WIDTH{i_mode}}, carry register = i_mode, counter = 0. Go to CALC.
- CALC:
  - o_ready=0.
  - Each edge adds digit k: A[k*DIGIT +: DIGIT] + B'[k*DIGIT +: DIGIT] + carry. Writes the sum digit into the result register, updates carry, increments k.
  - On the edge that processes digit NDIG−1:
    - o_carry = final carry.
    - o_ovf = carry into MSB XOR carry out of MSB.
    - o_zero = (full result == 0).
    - o_valid=1. Go to DONE.
- Latency: o_valid rises NDIG edges after the accepting edge (NDIG=2 at defaults). NDIG=1 is legal: one CALC edge.
- DONE:
  - o_valid=1, o_ready=0. o_sum and all flags held stable.
  - On i_valid-independent edge with i_ready=1: o_valid=0, go to IDLE. Flags and o_sum keep their last values until the next completion.
- No overlap: no new operand is accepted in DONE, even if i_ready=1 on that edge. This means one bubble cycle per operation.
- i_valid outside IDLE is ignored; the source holds it under the standard valid/ready rule.
- Changes on i_A, i_B or i_mode after acceptance do not affect the in-flight result.
- Reset asserted in any state immediately forces reset values; the partial result is discarded.
- Width rule: all internal digit sums are DIGIT+1 bits. Carry into MSB is taken from bit DIGIT−1 of the last digit add.

Optional Feature:
- Macro ADDSUB_SAT_EN.
- Defined: when o_ovf=1, o_sum saturates.
  - If A MSB=0: {0, all 1s} (signed max).
  - Else: {1, all 0s} (signed min).
  - o_ovf is still reported as 1. o_zero is computed on the saturated value. o_carry is unchanged (raw).
- Undefined: o_sum is the wrapped modulo-2^WIDTH result. No saturation logic is present.

Test Plan:
All scenarios use WIDTH=8, DIGIT=4.
1. A=0x3C, B=0x15, mode=0 -> o_sum=0x51, carry=0, ovf=0, zero=0. o_valid exactly 2 edges after acceptance; o_ready low for 3 cycles total.
2. A=0x05, B=0x05, mode=1 -> o_sum=0x00, carry=1, ovf=0, zero=1. Then A=0x03, B=0x05, mode=1 -> o_sum=0xFE, carry=0, ovf=0, zero=0.
3. A=0x7F, B=0x01, mode=0 -> ovf=1, carry=0. o_sum=0x80 without macro, 0x7F with ADDSUB_SAT_EN. A=0x80, B=0x01, mode=1 -> ovf=1, o_sum=0x7F / 0x80 (saturated).
4. Backpressure: hold i_ready=0 for 5 cycles in DONE -> o_valid, o_sum and flags stable. o_ready=0. Pulsed i_valid with new operands is ignored. After i_ready=1: IDLE one cycle later, next operand accepted and correct.
5. Assert i_rst_n=0 mid-CALC (after the first digit edge) -> o_valid=0, o_ready=1, o_sum=0 and flags 0 immediately, without a clock edge. A fresh operation after release produces the correct result.
6. WIDTH=8, DIGIT=8 and WIDTH=16, DIGIT=4: random add/sub pairs vs reference model. Latency is 1 and 4 respectively. All flags match.

Source files
------------

// File: rtl/addsub_serial_nbit.sv
// Digit-serial two's-complement adder/subtractor with valid/ready on both sides.
// Define ADDSUB_SAT_EN to saturate o_sum to signed max/min on overflow.
module addsub_serial_nbit #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_A,
   input  logic [WIDTH-1:0] i_B,
   input  logic             i_mode,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_carry,
   output logic             o_ovf,
   output logic             o_zero
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q;
   logic             carry_q;
   logic [WIDTH-1:0] a_q, b_q, work_q, work_d, fin_d;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q, ovf_q, zero_q;

   logic [DIGIT-1:0] a_dig, b_dig;
   logic [DIGIT:0]   dsum;
   logic             msb_cin, raw_ovf, last_dig;

`ifdef ADDSUB_SAT_EN
   function automatic logic [WIDTH-1:0] saturate(input logic a_msb);
      return a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
   endfunction
`endif

   // One DIGIT+1 bit add per clock; the top bit is the carry into the next digit.
   assign a_dig    = a_q[cnt_q*DIGIT +: DIGIT];
   assign b_dig    = b_q[cnt_q*DIGIT +: DIGIT];
   assign dsum     = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
   assign msb_cin  = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ dsum[DIGIT-1];
   assign raw_ovf  = msb_cin ^ dsum[DIGIT];
   assign last_dig = (cnt_q == LAST);

   always_comb begin
      work_d = work_q;
      work_d[cnt_q*DIGIT +: DIGIT] = dsum[DIGIT-1:0];
`ifdef ADDSUB_SAT_EN
      fin_d = raw_ovf ? saturate(a_q[WIDTH-1]) : work_d;
`else
      fin_d = work_d;
`endif
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (i_valid)  state_d = CALC;
         CALC:    if (last_dig) state_d = DONE;
         DONE:    if (i_ready)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      o_ready = (state_q == IDLE);
      o_valid = (state_q == DONE);
   end

   // Result and flags only change on the final digit edge, so they hold through DONE and IDLE.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         work_q  <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (i_valid) begin
                  a_q     <= i_A;
                  b_q     <= i_B ^ {WIDTH{i_mode}};
                  carry_q <= i_mode;
                  cnt_q   <= '0;
               end
            end
            CALC: begin
               work_q  <= work_d;
               carry_q <= dsum[DIGIT];
               cnt_q   <= cnt_q + 1'b1;
               if (last_dig) begin
                  sum_q  <= fin_d;
                  cout_q <= dsum[DIGIT];
                  ovf_q  <= raw_ovf;
                  zero_q <= (fin_d == '0);
               end
            end
            default: ;
         endcase
      end
   end

   assign o_sum   = sum_q;
   assign o_carry = cout_q;
   assign o_ovf   = ovf_q;
   assign o_zero  = zero_q;

endmodule

// File: tb/tb_addsub_serial_nbit.sv
// Bench for addsub_serial_nbit: three instances (8/4, 8/8, 16/4) checked against an arithmetic model.
module tb_addsub_serial_nbit;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        vld [3];
   logic        rdy [3];
   logic        md  [3];
   logic [15:0] opa [3];
   logic [15:0] opb [3];

   logic [7:0]  sum0, sum1;
   logic [15:0] sum2;
   logic        rdy0, rdy1, rdy2, val0, val1, val2;
   logic        cry0, cry1, cry2, ovf0, ovf1, ovf2, zer0, zer1, zer2;

   logic [15:0] sum_w [3];
   logic        rdyo_w [3];
   logic        valo_w [3];
   logic        cry_w [3];
   logic        ovf_w [3];
   logic        zer_w [3];

   addsub_serial_nbit #(.WIDTH(8), .DIGIT(4)) u_d0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld[0]), .o_ready(rdy0),
      .i_A(opa[0][7:0]), .i_B(opb[0][7:0]), .i_mode(md[0]), .o_valid(val0),
      .i_ready(rdy[0]), .o_sum(sum0), .o_carry(cry0), .o_ovf(ovf0), .o_zero(zer0));

   addsub_serial_nbit #(.WIDTH(8), .DIGIT(8)) u_d1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld[1]), .o_ready(rdy1),
      .i_A(opa[1][7:0]), .i_B(opb[1][7:0]), .i_mode(md[1]), .o_valid(val1),
      .i_ready(rdy[1]), .o_sum(sum1), .o_carry(cry1), .o_ovf(ovf1), .o_zero(zer1));

   addsub_serial_nbit #(.WIDTH(16), .DIGIT(4)) u_d2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld[2]), .o_ready(rdy2),
      .i_A(opa[2]), .i_B(opb[2]), .i_mode(md[2]), .o_valid(val2),
      .i_ready(rdy[2]), .o_sum(sum2), .o_carry(cry2), .o_ovf(ovf2), .o_zero(zer2));

   always_comb begin
      sum_w[0] = {8'h00, sum0}; sum_w[1] = {8'h00, sum1}; sum_w[2] = sum2;
      rdyo_w[0] = rdy0; rdyo_w[1] = rdy1; rdyo_w[2] = rdy2;
      valo_w[0] = val0; valo_w[1] = val1; valo_w[2] = val2;
      cry_w[0] = cry0;  cry_w[1] = cry1;  cry_w[2] = cry2;
      ovf_w[0] = ovf0;  ovf_w[1] = ovf1;  ovf_w[2] = ovf2;
      zer_w[0] = zer0;  zer_w[1] = zer1;  zer_w[2] = zer2;
   end

   function automatic int wid(input int d);
      return (d == 2) ? 16 : 8;
   endfunction

   function automatic int ndig(input int d);
      return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
   endfunction

   // Packed result: {zero, ovf, carry, sum[15:0]}
   function automatic logic [18:0] pk(input logic z, input logic o, input logic c, input logic [15:0] s);
      return {z, o, c, s};
   endfunction

   function automatic logic [18:0] ref_op(input int w, input logic [15:0] a, input logic [15:0] b, input logic m);
      int mask, ua, ub, raw, sa, sb, ex, smax, smin;
      logic [15:0] s;
      logic c, o;
      mask = (1 << w) - 1;
      ua   = int'(a) & mask;
      ub   = int'(b) & mask;
      raw  = m ? (ua + ((~ub) & mask) + 1) : (ua + ub);
      c    = ((raw >> w) & 1) != 0;
      s    = 16'(raw & mask);
      sa   = (ua >= (1 << (w-1))) ? ua - (1 << w) : ua;
      sb   = (ub >= (1 << (w-1))) ? ub - (1 << w) : ub;
      ex   = m ? (sa - sb) : (sa + sb);
      smax = (1 << (w-1)) - 1;
      smin = -(1 << (w-1));
      o    = (ex > smax) || (ex < smin);
`ifdef ADDSUB_SAT_EN
      if (o) s = (sa >= 0) ? 16'(smax) : 16'(1 << (w-1));
`endif
      return pk(s == 16'h0, o, c, s);
   endfunction

   // Transaction-level model: idle -> busy for NDIG edges -> result held until consumed.
   int          mph  [3];
   int          mleft[3];
   logic [18:0] mpend[3];
   logic [18:0] mout [3];

   always @(posedge clk or negedge rst_n) begin
      for (int d = 0; d < 3; d++) begin
         if (!rst_n) begin
            mph[d]   <= 0;
            mleft[d] <= 0;
            mpend[d] <= '0;
            mout[d]  <= '0;
         end else begin
            case (mph[d])
               0: if (vld[d]) begin
                  mpend[d] <= ref_op(wid(d), opa[d], opb[d], md[d]);
                  mleft[d] <= ndig(d);
                  mph[d]   <= 1;
               end
               1: if (mleft[d] == 1) begin
                  mph[d]  <= 2;
                  mout[d] <= mpend[d];
               end else begin
                  mleft[d] <= mleft[d] - 1;
               end
               default: if (rdy[d]) mph[d] <= 0;
            endcase
         end
      end
   end

   int          n_chk  = 0;
   int          n_fail = 0;
   logic        lit_on = 1'b0;
   logic [18:0] lit_val = '0;
   logic        mdl_done = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   always begin
      @(negedge clk or negedge rst_n);
      #1;
      if (!mdl_done) begin
         mdl_done = 1'b1;
         chk("mdl_add",   32'(ref_op(8, 16'h3C, 16'h15, 1'b0)), 32'(pk(0, 0, 0, 16'h51)));
         chk("mdl_sub0",  32'(ref_op(8, 16'h05, 16'h05, 1'b1)), 32'(pk(1, 0, 1, 16'h00)));
         chk("mdl_subn",  32'(ref_op(8, 16'h03, 16'h05, 1'b1)), 32'(pk(0, 0, 0, 16'hFE)));
`ifdef ADDSUB_SAT_EN
         chk("mdl_ovf16", 32'(ref_op(16, 16'h7FFF, 16'h0001, 1'b0)), 32'(pk(0, 1, 0, 16'h7FFF)));
`else
         chk("mdl_ovf16", 32'(ref_op(16, 16'h7FFF, 16'h0001, 1'b0)), 32'(pk(0, 1, 0, 16'h8000)));
`endif
      end
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("u%0d_ready", d), 32'(rdyo_w[d]), 32'(mph[d] == 0));
         chk($sformatf("u%0d_valid", d), 32'(valo_w[d]), 32'(mph[d] == 2));
         chk($sformatf("u%0d_result", d),
             32'(pk(zer_w[d], ovf_w[d], cry_w[d], sum_w[d])), 32'(mout[d]));
      end
      if (lit_on && mph[0] == 2)
         chk("u0_literal", 32'(pk(zer0, ovf0, cry0, {8'h00, sum0})), 32'(lit_val));
      if (!rst_n) begin
         chk("rst_sum",   32'(sum0), 32'h0);
         chk("rst_flags", 32'({val0, rdy0, cry0, ovf0, zer0}), 32'b01000);
      end
   end

   task automatic wait_ph(input int d, input int ph);
      for (int i = 0; i < 60; i++) begin
         if (mph[d] == ph) return;
         @(negedge clk);
      end
      $display("FAIL timeout u%0d waiting for phase %0d", d, ph);
      $fatal(1, "bench stopped on timeout");
   endtask

   task automatic launch(input int d, input logic [15:0] a, input logic [15:0] b, input logic m,
                         input logic use_lit, input logic [18:0] lv);
      wait_ph(d, 0);
      lit_on  = use_lit;
      lit_val = lv;
      opa[d] = a; opb[d] = b; md[d] = m; vld[d] = 1'b1;
      @(negedge clk);
      vld[d] = 1'b0;
      opa[d] = 16'($urandom); opb[d] = 16'($urandom); md[d] = 1'($urandom);
   endtask

   task automatic run(input int d, input logic [15:0] a, input logic [15:0] b, input logic m,
                      input logic use_lit, input logic [18:0] lv);
      launch(d, a, b, m, use_lit, lv);
      wait_ph(d, 2);
      wait_ph(d, 0);
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         vld[d] = 1'b0; rdy[d] = 1'b1; md[d] = 1'b0; opa[d] = '0; opb[d] = '0;
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run(0, 16'h3C, 16'h15, 1'b0, 1'b1, pk(0, 0, 0, 16'h51));
      run(0, 16'h05, 16'h05, 1'b1, 1'b1, pk(1, 0, 1, 16'h00));
      run(0, 16'h03, 16'h05, 1'b1, 1'b1, pk(0, 0, 0, 16'hFE));
`ifdef ADDSUB_SAT_EN
      run(0, 16'h7F, 16'h01, 1'b0, 1'b1, pk(0, 1, 0, 16'h7F));
      run(0, 16'h80, 16'h01, 1'b1, 1'b1, pk(0, 1, 1, 16'h80));
`else
      run(0, 16'h7F, 16'h01, 1'b0, 1'b1, pk(0, 1, 0, 16'h80));
      run(0, 16'h80, 16'h01, 1'b1, 1'b1, pk(0, 1, 1, 16'h7F));
`endif

      rdy[0] = 1'b0;
      launch(0, 16'h22, 16'h11, 1'b0, 1'b1, pk(0, 0, 0, 16'h33));
      wait_ph(0, 2);
      for (int i = 0; i < 5; i++) begin
         if (i == 1) begin vld[0] = 1'b1; opa[0] = 16'h44; opb[0] = 16'h44; md[0] = 1'b1; end
         if (i == 3) vld[0] = 1'b0;
         @(negedge clk);
      end
      rdy[0] = 1'b1;
      @(negedge clk);
      run(0, 16'hF0, 16'h20, 1'b0, 1'b1, pk(0, 0, 1, 16'h10));

      launch(0, 16'h12, 16'h34, 1'b0, 1'b0, '0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #4;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run(0, 16'h12, 16'h34, 1'b0, 1'b1, pk(0, 0, 0, 16'h46));
      lit_on = 1'b0;

      run(1, 16'h7F, 16'h80, 1'b1, 1'b0, '0);
      run(1, 16'h00, 16'h00, 1'b1, 1'b0, '0);
      run(2, 16'h8000, 16'h0001, 1'b1, 1'b0, '0);
      run(2, 16'hFFFF, 16'h0001, 1'b0, 1'b0, '0);
      for (int i = 0; i < 16; i++) begin
         run(1, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)), 1'($urandom), 1'b0, '0);
         run(2, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0, '0);
      end

      repeat (3) @(negedge clk);
      #2;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
